mmio_register_bank: RTL and testbench
=====================================

MMIO_REGISTER_BANK -- requirements
Module: mmio_register_bank

Interface
REQ-001 SHALL have parameter ADDR_START, default 0: byte base address, word-aligned.
REQ-002 SHALL have parameter WORD_COUNT, default 4 (range 1..256): number of 32-bit registers.
REQ-003 SHALL have parameter RES_LATENCY, default 1 (range 1..4): request-accept to response-valid cycles.
REQ-004 SHALL have parameter RESET_VALUE, default 0: WORD_W-bit value loaded into every register on reset.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port areset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_req_valid  input  1  request present.
REQ-008 SHALL have port i_req_addr  input  ADDR_W  byte address.
REQ-009 SHALL have port i_req_wr_data  input  WORD_W  write data, LSB-justified.
REQ-010 SHALL have port i_req_wr_en  input  1  1=write, 0=read.
REQ-011 SHALL have port i_req_count  input  MEM_COUNT_W  access size (BYTE/HALF/WORD).
REQ-012 SHALL have port i_req_signed  input  1  sign-extend byte/half reads.
REQ-013 SHALL have port o_res_valid  output  1  response strobe, one cycle per accepted request.
REQ-014 SHALL have port o_res_rd_data  output  WORD_W  read data.
REQ-015 SHALL have port o_res_code  output  MEM_CODE_W  result code.
REQ-016 SHALL have port o_exposed_mem  output  WORD_W*WORD_COUNT  all registers; word j at bits [32j+31:32j].

Function
REQ-017 SHALL accept a request every cycle that i_req_valid=1; a request with i_req_count=MEM_COUNT_NONE produces o_res_valid with MEM_CODE_INVALID.
REQ-018 SHALL classify each request in the accept cycle, in priority order: misaligned (HALF with addr[0]!=0, WORD with addr[1:0]!=0) -> MEM_CODE_MISALIGNED; word index outside [ADDR_START>>2, (ADDR_START>>2)+WORD_COUNT-1] (both bounds checked) -> MEM_CODE_OUT_OF_BOUNDS; unknown count -> MEM_CODE_INVALID; otherwise READ/WRITE.
REQ-019 SHALL commit writes at the accept edge, updating only the addressed byte lanes; all other lanes and registers SHALL be unchanged.
REQ-020 SHALL sample read data at the accept edge, so a read accepted the cycle after a write to the same word returns the new value; a read and write cannot coexist in one cycle.
REQ-021 SHALL zero-extend byte/half read data when i_req_signed=0 and sign-extend from bit 7/15 when 1; WORD ignores i_req_signed.
REQ-022 SHALL return o_res_rd_data=0 for every non-READ code, including writes.
REQ-023 SHALL present the response exactly RES_LATENCY cycles after acceptance via a shift pipeline; back-to-back requests yield back-to-back responses in order.
REQ-024 SHALL drive o_res_valid=0, o_res_rd_data=0 and o_res_code=MEM_CODE_INVALID in any cycle with no response.
REQ-025 SHALL update o_exposed_mem combinationally from register state (visible the cycle after a write edge).

Reset
REQ-026 SHALL, while areset=1, asynchronously set all registers to RESET_VALUE, clear all pipeline stages, and drive outputs per REQ-024.
REQ-027 SHALL discard in-flight responses when reset asserts mid-pipeline; no o_res_valid emerges for them after release.
REQ-028 SHALL ignore i_req_valid in the cycle areset deasserts only if areset is still high at that edge.

Configuration
REQ-029 SHALL, with RWREGS_LOCK_EN defined, add a lock register at word index (ADDR_START>>2)+WORD_COUNT; bit j set locks register j (j<32).
REQ-030 SHALL, with RWREGS_LOCK_EN, make the lock register writable only to set bits (sticky until reset), readable normally, and reject writes to locked registers with MEM_CODE_LOCKED, state unchanged.
REQ-031 SHALL, without RWREGS_LOCK_EN, have no lock register; that address returns MEM_CODE_OUT_OF_BOUNDS.

Structure
REQ-032 SHALL take ADDR_W, WORD_W, MEM_COUNT_* from config.vh/mem_codes.vh; MEM_CODE_LOCKED SHALL be added to mem_codes.vh.
REQ-033 SHALL implement the response pipeline as sub-module mem_res_pipe (parameter DEPTH, carries valid/data/code).

Verification
REQ-034 SHALL test: reset with RESET_VALUE=32'hA5A5_A5A5, ADDR_START=0x100 -> read WORD 0x104 after RES_LATENCY cycles returns A5A5A5A5, code READ.
REQ-035 SHALL test: write BYTE 0x80 to 0x101, then read BYTE 0x101 signed -> FFFF_FF80; unsigned -> 0000_0080; word 0x100 = A5A5_80A5.
REQ-036 SHALL test: HALF to 0x103 -> MISALIGNED; WORD to 0x0FC and to 0x110 (WORD_COUNT=4) -> OUT_OF_BOUNDS, data 0, no state change.
REQ-037 SHALL test: RES_LATENCY=3, four back-to-back requests -> four consecutive o_res_valid pulses starting cycle 3, in order.
REQ-038 SHALL test: areset pulsed with two requests in flight -> no o_res_valid afterward, registers at RESET_VALUE.
REQ-039 SHALL test (RWREGS_LOCK_EN): write 0x1 to lock word 0x110, then WORD write to 0x100 -> MEM_CODE_LOCKED, value unchanged; write 0x0 to lock -> bit stays 1.

Source files
------------

// File: rtl/mmio_register_bank_pkg.sv
// Shared widths, access-size and result-code encodings for the MMIO register bank.
// Holds the config/mem_codes constants, including MEM_CODE_LOCKED.
package mmio_register_bank_pkg;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned WORD_W      = 32;
   localparam int unsigned MEM_COUNT_W = 2;
   localparam int unsigned MEM_CODE_W  = 3;

   localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
   localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
   localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
   localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

   localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID       = 3'd0;
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ          = 3'd1;
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE         = 3'd2;
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED    = 3'd3;
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = 3'd4;
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_LOCKED        = 3'd5;

   typedef struct packed {
      logic                  valid;
      logic [WORD_W-1:0]     data;
      logic [MEM_CODE_W-1:0] code;
   } mem_res_t;

   localparam mem_res_t MEM_RES_IDLE = '{valid: 1'b0, data: '0, code: MEM_CODE_INVALID};

   // Expand a 4-bit byte-lane enable into a 32-bit bit mask.
   function automatic logic [WORD_W-1:0] lane_bits(input logic [3:0] lanes);
      return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
   endfunction

endpackage

// File: rtl/mem_res_pipe.sv
// Fixed-latency response shift pipeline; idle stages present the no-response encoding.
module mem_res_pipe
   import mmio_register_bank_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic     clk,
   input  logic     areset,
   input  mem_res_t i_res,
   output mem_res_t o_res
);

   mem_res_t r_stage [DEPTH];

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            r_stage[k] <= MEM_RES_IDLE;
         end
      end else begin
         r_stage[0] <= i_res;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            r_stage[k] <= r_stage[k-1];
         end
      end
   end

   assign o_res = r_stage[DEPTH-1].valid ? r_stage[DEPTH-1] : MEM_RES_IDLE;

endmodule

// File: rtl/mmio_register_bank.sv
// Bank of WORD_COUNT 32-bit MMIO registers with byte/half/word access and fixed-latency responses.
// Optional write-lock register enabled by defining RWREGS_LOCK_EN.
module mmio_register_bank
   import mmio_register_bank_pkg::*;
#(
   parameter logic [ADDR_W-1:0] ADDR_START  = '0,
   parameter int unsigned       WORD_COUNT  = 4,
   parameter int unsigned       RES_LATENCY = 1,
   parameter logic [WORD_W-1:0] RESET_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         areset,
   input  logic                         i_req_valid,
   input  logic [ADDR_W-1:0]            i_req_addr,
   input  logic [WORD_W-1:0]            i_req_wr_data,
   input  logic                         i_req_wr_en,
   input  logic [MEM_COUNT_W-1:0]       i_req_count,
   input  logic                         i_req_signed,
   output logic                         o_res_valid,
   output logic [WORD_W-1:0]            o_res_rd_data,
   output logic [MEM_CODE_W-1:0]        o_res_code,
   output logic [WORD_W*WORD_COUNT-1:0] o_exposed_mem
);

   localparam int unsigned      IDX_W    = ADDR_W - 2;
   localparam int unsigned      SEL_W    = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
   localparam logic [IDX_W-1:0] BASE_IDX = ADDR_START[ADDR_W-1:2];

   logic [WORD_W-1:0]     r_mem [WORD_COUNT];

   logic [IDX_W-1:0]      w_rel;
   logic [SEL_W-1:0]      w_sel;
   logic                  w_in_range;
   logic                  w_misaligned;
   logic                  w_is_lock;
   logic                  w_locked;
   logic [WORD_W-1:0]     w_lock_word;
   logic [WORD_W-1:0]     w_cur_word;
   logic [WORD_W-1:0]     w_rd_shift;
   logic [WORD_W-1:0]     w_rd_ext;
   logic [WORD_W-1:0]     w_wr_word;
   logic [WORD_W-1:0]     w_bit_mask;
   logic [WORD_W-1:0]     w_merged;
   logic [3:0]            w_lanes;
   logic [MEM_CODE_W-1:0] w_code;
   mem_res_t              w_res_in;
   mem_res_t              w_res_out;

   // Wrapping subtract: one unsigned compare covers both the lower and upper bound.
   assign w_rel      = i_req_addr[ADDR_W-1:2] - BASE_IDX;
   assign w_sel      = w_rel[SEL_W-1:0];
   assign w_in_range = (w_rel < IDX_W'(WORD_COUNT));

`ifdef RWREGS_LOCK_EN
   logic [WORD_W-1:0] r_lock;

   assign w_is_lock   = (w_rel == IDX_W'(WORD_COUNT));
   assign w_locked    = w_in_range && (w_rel < IDX_W'(32)) && r_lock[w_rel[4:0]];
   assign w_lock_word = r_lock;

   // Lock bits are sticky: writes can only set them.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_lock <= '0;
      end else if (i_req_valid && (w_code == MEM_CODE_WRITE) && w_is_lock) begin
         r_lock <= r_lock | (w_wr_word & w_bit_mask);
      end
   end
`else
   assign w_is_lock   = 1'b0;
   assign w_locked    = 1'b0;
   assign w_lock_word = '0;
`endif

   always_comb begin
      w_misaligned = 1'b0;
      if (i_req_count == MEM_COUNT_HALF) begin
         w_misaligned = i_req_addr[0];
      end else if (i_req_count == MEM_COUNT_WORD) begin
         w_misaligned = |i_req_addr[1:0];
      end
   end

   always_comb begin
      w_code = MEM_CODE_INVALID;
      if (w_misaligned) begin
         w_code = MEM_CODE_MISALIGNED;
      end else if (!w_in_range && !w_is_lock) begin
         w_code = MEM_CODE_OUT_OF_BOUNDS;
      end else if (i_req_count == MEM_COUNT_NONE) begin
         w_code = MEM_CODE_INVALID;
      end else if (!i_req_wr_en) begin
         w_code = MEM_CODE_READ;
      end else if (w_locked) begin
         w_code = MEM_CODE_LOCKED;
      end else begin
         w_code = MEM_CODE_WRITE;
      end
   end

   assign w_cur_word = w_is_lock ? w_lock_word : r_mem[w_sel];

   always_comb begin
      w_lanes   = 4'b0000;
      w_wr_word = i_req_wr_data;
      case (i_req_count)
         MEM_COUNT_BYTE: begin
            w_lanes   = 4'b0001 << i_req_addr[1:0];
            w_wr_word = {4{i_req_wr_data[7:0]}};
         end
         MEM_COUNT_HALF: begin
            w_lanes   = 4'b0011 << {i_req_addr[1], 1'b0};
            w_wr_word = {2{i_req_wr_data[15:0]}};
         end
         MEM_COUNT_WORD: w_lanes = 4'b1111;
         default:        w_lanes = 4'b0000;
      endcase
   end

   assign w_bit_mask = lane_bits(w_lanes);
   assign w_merged   = (w_cur_word & ~w_bit_mask) | (w_wr_word & w_bit_mask);
   assign w_rd_shift = w_cur_word >> {i_req_addr[1:0], 3'b000};

   always_comb begin
      w_rd_ext = w_rd_shift;
      case (i_req_count)
         MEM_COUNT_BYTE:
            w_rd_ext = i_req_signed ? {{24{w_rd_shift[7]}}, w_rd_shift[7:0]}
                                    : {24'h0, w_rd_shift[7:0]};
         MEM_COUNT_HALF:
            w_rd_ext = i_req_signed ? {{16{w_rd_shift[15]}}, w_rd_shift[15:0]}
                                    : {16'h0, w_rd_shift[15:0]};
         default: w_rd_ext = w_rd_shift;
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         for (int unsigned j = 0; j < WORD_COUNT; j++) begin
            r_mem[j] <= RESET_VALUE;
         end
      end else if (i_req_valid && (w_code == MEM_CODE_WRITE) && !w_is_lock) begin
         r_mem[w_sel] <= w_merged;
      end
   end

   always_comb begin
      w_res_in = MEM_RES_IDLE;
      if (i_req_valid) begin
         w_res_in.valid = 1'b1;
         w_res_in.code  = w_code;
         w_res_in.data  = (w_code == MEM_CODE_READ) ? w_rd_ext : '0;
      end
   end

   mem_res_pipe #(
      .DEPTH (RES_LATENCY)
   ) u_res_pipe (
      .clk    (clk),
      .areset (areset),
      .i_res  (w_res_in),
      .o_res  (w_res_out)
   );

   assign o_res_valid   = w_res_out.valid;
   assign o_res_rd_data = w_res_out.data;
   assign o_res_code    = w_res_out.code;

   for (genvar j = 0; j < WORD_COUNT; j++) begin : g_expose
      assign o_exposed_mem[j*WORD_W +: WORD_W] = r_mem[j];
   end

endmodule

// File: tb/tb_mmio_register_bank.sv
// Directed, table-driven bench for mmio_register_bank (ADDR_START=0x100, 4 words, latency 3).
module tb_mmio_register_bank;
   import mmio_register_bank_pkg::*;

   localparam int unsigned LAT = 3;
   localparam int unsigned WC  = 4;
   localparam logic [31:0] RV  = 32'hA5A5_A5A5;
`ifdef RWREGS_LOCK_EN
   localparam logic [31:0] OOB_HI = 32'h114;
`else
   localparam logic [31:0] OOB_HI = 32'h110;
`endif

   logic                   clk = 1'b0;
   logic                   areset = 1'b1;
   logic                   i_req_valid = 1'b0;
   logic [ADDR_W-1:0]      i_req_addr = '0;
   logic [WORD_W-1:0]      i_req_wr_data = '0;
   logic                   i_req_wr_en = 1'b0;
   logic [MEM_COUNT_W-1:0] i_req_count = MEM_COUNT_NONE;
   logic                   i_req_signed = 1'b0;
   logic                   o_res_valid;
   logic [WORD_W-1:0]      o_res_rd_data;
   logic [MEM_CODE_W-1:0]  o_res_code;
   logic [WORD_W*WC-1:0]   o_exposed_mem;

   always #5 clk = ~clk;

   mmio_register_bank #(
      .ADDR_START  (32'h100),
      .WORD_COUNT  (WC),
      .RES_LATENCY (LAT),
      .RESET_VALUE (RV)
   ) dut (
      .clk           (clk),
      .areset        (areset),
      .i_req_valid   (i_req_valid),
      .i_req_addr    (i_req_addr),
      .i_req_wr_data (i_req_wr_data),
      .i_req_wr_en   (i_req_wr_en),
      .i_req_count   (i_req_count),
      .i_req_signed  (i_req_signed),
      .o_res_valid   (o_res_valid),
      .o_res_rd_data (o_res_rd_data),
      .o_res_code    (o_res_code),
      .o_exposed_mem (o_exposed_mem)
   );

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        wr;
      logic [1:0]  cnt;
      logic        sgn;
      logic [2:0]  code;
      logic [31:0] data;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic [31:0] BB_ADDR [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
   localparam logic [31:0] BB_EXP  [4] = '{32'hA5A5_80A5, 32'hA5A5_A5A5, 32'hBEEF_A5A5,
                                           32'h1234_5678};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic add(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic wr, input logic [1:0] cnt, input logic sgn,
                      input logic [2:0] code, input logic [31:0] data);
      vec_t v;
      v.name = name; v.addr = addr; v.wdata = wdata; v.wr = wr;
      v.cnt = cnt; v.sgn = sgn; v.code = code; v.data = data;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                        input logic [1:0] cnt, input logic sgn);
      i_req_valid = 1'b1; i_req_addr = addr; i_req_wr_data = wdata;
      i_req_wr_en = wr; i_req_count = cnt; i_req_signed = sgn;
   endtask

   task automatic idle();
      i_req_valid = 1'b0; i_req_addr = '0; i_req_wr_data = '0;
      i_req_wr_en = 1'b0; i_req_count = MEM_COUNT_NONE; i_req_signed = 1'b0;
   endtask

   // Issue one request from a negedge, then wait (bounded) for its response.
   task automatic run_vec(input vec_t v);
      int lat;
      drive(v.addr, v.wdata, v.wr, v.cnt, v.sgn);
      @(posedge clk);
      #1 idle();
      lat = 0;
      while (lat < 8) begin
         @(negedge clk);
         lat++;
         if (o_res_valid) break;
      end
      check({v.name, " latency"}, 32'(lat), 32'(LAT));
      check({v.name, " code"}, 32'(o_res_code), 32'(v.code));
      check({v.name, " data"}, o_res_rd_data, v.data);
   endtask

   task automatic run_all();
      foreach (vecs[i]) run_vec(vecs[i]);
      vecs.delete();
   endtask

   task automatic check_mem(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
      check({tag, " mem0"}, o_exposed_mem[31:0],   w0);
      check({tag, " mem1"}, o_exposed_mem[63:32],  w1);
      check({tag, " mem2"}, o_exposed_mem[95:64],  w2);
      check({tag, " mem3"}, o_exposed_mem[127:96], w3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;
      idle();
      areset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset valid", 32'(o_res_valid), 32'd0);
      check("reset data", o_res_rd_data, 32'd0);
      check("reset code", 32'(o_res_code), 32'(MEM_CODE_INVALID));
      check_mem("reset", RV, RV, RV, RV);
      areset = 1'b0;
      @(negedge clk);

      add("rd word 0x104",      32'h104, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0, MEM_CODE_READ, RV);
      add("wr byte 0x101",      32'h101, 32'h80, 1'b1, MEM_COUNT_BYTE, 1'b0, MEM_CODE_WRITE, 0);
      add("rd byte 0x101 s",    32'h101, 32'h0, 1'b0, MEM_COUNT_BYTE, 1'b1, MEM_CODE_READ,
          32'hFFFF_FF80);
      add("rd byte 0x101 u",    32'h101, 32'h0, 1'b0, MEM_COUNT_BYTE, 1'b0, MEM_CODE_READ,
          32'h0000_0080);
      add("rd word 0x100",      32'h100, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0, MEM_CODE_READ,
          32'hA5A5_80A5);
      add("half 0x103",         32'h103, 32'h0, 1'b0, MEM_COUNT_HALF, 1'b0,
          MEM_CODE_MISALIGNED, 0);
      add("wr word 0x0FC",      32'h0FC, 32'hDEAD_BEEF, 1'b1, MEM_COUNT_WORD, 1'b0,
          MEM_CODE_OUT_OF_BOUNDS, 0);
      add("wr word past end",   OOB_HI, 32'hDEAD_BEEF, 1'b1, MEM_COUNT_WORD, 1'b0,
          MEM_CODE_OUT_OF_BOUNDS, 0);
      add("rd word 0x102",      32'h102, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0,
          MEM_CODE_MISALIGNED, 0);
      add("none 0x108",         32'h108, 32'h0, 1'b0, MEM_COUNT_NONE, 1'b0, MEM_CODE_INVALID, 0);
      add("wr half 0x10A",      32'h10A, 32'h1234_BEEF, 1'b1, MEM_COUNT_HALF, 1'b0,
          MEM_CODE_WRITE, 0);
      add("rd half 0x10A s",    32'h10A, 32'h0, 1'b0, MEM_COUNT_HALF, 1'b1, MEM_CODE_READ,
          32'hFFFF_BEEF);
      add("rd half 0x10A u",    32'h10A, 32'h0, 1'b0, MEM_COUNT_HALF, 1'b0, MEM_CODE_READ,
          32'h0000_BEEF);
      add("rd word 0x108",      32'h108, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0, MEM_CODE_READ,
          32'hBEEF_A5A5);
      add("wr word 0x10C",      32'h10C, 32'h1234_5678, 1'b1, MEM_COUNT_WORD, 1'b0,
          MEM_CODE_WRITE, 0);
      add("rd byte 0x10F u",    32'h10F, 32'h0, 1'b0, MEM_COUNT_BYTE, 1'b0, MEM_CODE_READ,
          32'h0000_0012);
      add("rd byte 0x10E s",    32'h10E, 32'h0, 1'b0, MEM_COUNT_BYTE, 1'b1, MEM_CODE_READ,
          32'h0000_0034);
      add("rd word 0x10C s",    32'h10C, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b1, MEM_CODE_READ,
          32'h1234_5678);
      run_all();
      check_mem("table", 32'hA5A5_80A5, RV, 32'hBEEF_A5A5, 32'h1234_5678);

      // Four back-to-back reads: responses expected in cycles LAT..LAT+3, in order.
      for (int c = 0; c < 10; c++) begin
         if (c > 0) begin
            if (c >= LAT && c < LAT + 4) begin
               check($sformatf("b2b valid c%0d", c), 32'(o_res_valid), 32'd1);
               check($sformatf("b2b data c%0d", c), o_res_rd_data, BB_EXP[c-LAT]);
               check($sformatf("b2b code c%0d", c), 32'(o_res_code), 32'(MEM_CODE_READ));
            end else begin
               check($sformatf("b2b valid c%0d", c), 32'(o_res_valid), 32'd0);
               check($sformatf("b2b idle data c%0d", c), o_res_rd_data, 32'd0);
               check($sformatf("b2b idle code c%0d", c), 32'(o_res_code),
                     32'(MEM_CODE_INVALID));
            end
         end
         if (c < 4) drive(BB_ADDR[c], 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0);
         else idle();
         @(negedge clk);
      end

      // Reset with a write and a read still in the response pipeline.
      drive(32'h104, 32'hCAFE_F00D, 1'b1, MEM_COUNT_WORD, 1'b0);
      @(posedge clk);
      #1 drive(32'h104, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0);
      @(posedge clk);
      #1 idle();
      check("pre-reset mem1", o_exposed_mem[63:32], 32'hCAFE_F00D);
      areset = 1'b1;
      #1;
      check("async reset valid", 32'(o_res_valid), 32'd0);
      check("async reset mem1", o_exposed_mem[63:32], RV);
      @(negedge clk);
      @(negedge clk);
      areset = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (o_res_valid) seen++;
      end
      check("flushed responses", 32'(seen), 32'd0);
      check_mem("post-reset", RV, RV, RV, RV);

`ifdef RWREGS_LOCK_EN
      add("lock set bit0",      32'h110, 32'h1, 1'b1, MEM_COUNT_WORD, 1'b0, MEM_CODE_WRITE, 0);
      add("lock read",          32'h110, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0, MEM_CODE_READ,
          32'h1);
      add("wr locked 0x100",    32'h100, 32'h1111_1111, 1'b1, MEM_COUNT_WORD, 1'b0,
          MEM_CODE_LOCKED, 0);
      add("rd locked 0x100",    32'h100, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0, MEM_CODE_READ, RV);
      add("lock write zero",    32'h110, 32'h0, 1'b1, MEM_COUNT_WORD, 1'b0, MEM_CODE_WRITE, 0);
      add("lock sticky",        32'h110, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0, MEM_CODE_READ,
          32'h1);
      add("wr unlocked 0x104",  32'h104, 32'h5A, 1'b1, MEM_COUNT_BYTE, 1'b0, MEM_CODE_WRITE, 0);
      add("rd unlocked 0x104",  32'h104, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0, MEM_CODE_READ,
          32'hA5A5_A55A);
      run_all();
      check_mem("lock", RV, 32'hA5A5_A55A, RV, RV);
`else
      add("no lock reg 0x110",  32'h110, 32'h1, 1'b1, MEM_COUNT_WORD, 1'b0,
          MEM_CODE_OUT_OF_BOUNDS, 0);
      add("rd 0x100 unlocked",  32'h100, 32'h0, 1'b0, MEM_COUNT_WORD, 1'b0, MEM_CODE_READ, RV);
      run_all();
      check_mem("no-lock", RV, RV, RV, RV);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
